// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: captures ALU result and control, lane-aligns store data,
// generates byte enables, traps misaligned accesses into a sticky fault and parks on HALT.
module ex_mem_stage (
  input  logic        clk,
  input  logic        i_reset,
  input  logic        i_step,
  input  logic        i_flush,
  input  logic [31:0] i_alu_result,
  input  logic [31:0] i_store_data,
  input  logic [4:0]  i_write_reg,
  input  logic        i_mem2Reg,
  input  logic        i_memRead,
  input  logic        i_memWrite,
  input  logic        i_regWrite,
  input  logic        i_sign_flag,
  input  logic [1:0]  i_width,
  input  logic        i_halt,
  output logic [31:0] o_alu_result,
  output logic [31:0] o_store_data,
  output logic [3:0]  o_byte_en,
  output logic [4:0]  o_write_reg,
  output logic        o_mem2Reg,
  output logic        o_memRead,
  output logic        o_memWrite,
  output logic        o_regWrite,
  output logic        o_sign_flag,
  output logic [1:0]  o_width,
  output logic [1:0]  o_addr_lo,
  output logic        o_halted,
  output logic        o_fault,
  output logic [31:0] o_fault_addr
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HALTED = 2'd1,
    FAULT  = 2'd2
  } state_t;

  state_t      state_q, state_d;

  logic [31:0] alu_result_q, alu_result_d;
  logic [31:0] store_data_q, store_data_d;
  logic [3:0]  byte_en_q, byte_en_d;
  logic [4:0]  write_reg_q, write_reg_d;
  logic        mem2reg_q, mem2reg_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;
  logic        reg_write_q, reg_write_d;
  logic        sign_flag_q, sign_flag_d;
  logic [1:0]  width_q, width_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic        halted_q, halted_d;
  logic        fault_q, fault_d;
  logic [31:0] fault_addr_q, fault_addr_d;

  logic        capture;
  logic        misaligned;
  logic        bubble;
  logic        fault_evt;
  logic        halt_evt;
  logic [31:0] aligned_data;
  logic [3:0]  lane_mask;

  // Width 11 falls into the word case for both alignment and fault checks.
  always_comb begin
    aligned_data = i_store_data;
    lane_mask    = 4'b1111;
    case (i_width)
      2'b00: begin
        aligned_data = {4{i_store_data[7:0]}};
        lane_mask    = 4'b0001 << i_alu_result[1:0];
      end
      2'b01: begin
        aligned_data = {2{i_store_data[15:0]}};
        lane_mask    = i_alu_result[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  always_comb begin
    capture    = (state_q == RUN) && !i_step;
    misaligned = (i_memRead || i_memWrite) &&
                 (((i_width == 2'b01) && i_alu_result[0]) ||
                  (i_width[1] && (i_alu_result[1:0] != 2'b00)));
    bubble     = i_flush || misaligned || i_halt;
    // Flush outranks both traps; misalignment outranks halt.
    fault_evt  = capture && !i_flush && misaligned;
    halt_evt   = capture && !i_flush && !misaligned && i_halt;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!i_reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (fault_evt) begin
          state_d = FAULT;
        end else if (halt_evt) begin
          state_d = HALTED;
        end
      end
      HALTED:  state_d = HALTED;
      FAULT:   state_d = FAULT;
      default: state_d = RUN;
    endcase
  end

  // Output logic
  always_comb begin
    alu_result_d = alu_result_q;
    store_data_d = store_data_q;
    byte_en_d    = byte_en_q;
    write_reg_d  = write_reg_q;
    mem2reg_d    = mem2reg_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    reg_write_d  = reg_write_q;
    sign_flag_d  = sign_flag_q;
    width_d      = width_q;
    addr_lo_d    = addr_lo_q;
    halted_d     = halted_q || halt_evt;
    fault_d      = fault_q || fault_evt;
    fault_addr_d = fault_evt ? i_alu_result : fault_addr_q;
    if (capture) begin
      alu_result_d = i_alu_result;
      store_data_d = aligned_data;
      write_reg_d  = i_write_reg;
      addr_lo_d    = i_alu_result[1:0];
      if (bubble) begin
        byte_en_d   = 4'b0000;
        mem2reg_d   = 1'b0;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        reg_write_d = 1'b0;
        sign_flag_d = 1'b0;
        width_d     = 2'b00;
      end else begin
        byte_en_d   = i_memWrite ? lane_mask : 4'b0000;
        mem2reg_d   = i_mem2Reg;
        mem_read_d  = i_memRead;
        mem_write_d = i_memWrite;
        reg_write_d = i_regWrite;
        sign_flag_d = i_sign_flag;
        width_d     = i_width;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!i_reset) begin
      alu_result_q <= '0;
      store_data_q <= '0;
      byte_en_q    <= '0;
      write_reg_q  <= '0;
      mem2reg_q    <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      reg_write_q  <= 1'b0;
      sign_flag_q  <= 1'b0;
      width_q      <= '0;
      addr_lo_q    <= '0;
      halted_q     <= 1'b0;
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
    end else begin
      alu_result_q <= alu_result_d;
      store_data_q <= store_data_d;
      byte_en_q    <= byte_en_d;
      write_reg_q  <= write_reg_d;
      mem2reg_q    <= mem2reg_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      reg_write_q  <= reg_write_d;
      sign_flag_q  <= sign_flag_d;
      width_q      <= width_d;
      addr_lo_q    <= addr_lo_d;
      halted_q     <= halted_d;
      fault_q      <= fault_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  assign o_alu_result = alu_result_q;
  assign o_store_data = store_data_q;
  assign o_byte_en    = byte_en_q;
  assign o_write_reg  = write_reg_q;
  assign o_mem2Reg    = mem2reg_q;
  assign o_memRead    = mem_read_q;
  assign o_memWrite   = mem_write_q;
  assign o_regWrite   = reg_write_q;
  assign o_sign_flag  = sign_flag_q;
  assign o_width      = width_q;
  assign o_addr_lo    = addr_lo_q;
  assign o_halted     = halted_q;
  assign o_fault      = fault_q;
  assign o_fault_addr = fault_addr_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: directed scenarios plus randomized traffic against a behavioural model.
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        i_reset, i_step, i_flush;
  logic [31:0] i_alu_result, i_store_data;
  logic [4:0]  i_write_reg;
  logic        i_mem2Reg, i_memRead, i_memWrite, i_regWrite, i_sign_flag;
  logic [1:0]  i_width;
  logic        i_halt;
  logic [31:0] o_alu_result, o_store_data;
  logic [3:0]  o_byte_en;
  logic [4:0]  o_write_reg;
  logic        o_mem2Reg, o_memRead, o_memWrite, o_regWrite, o_sign_flag;
  logic [1:0]  o_width, o_addr_lo;
  logic        o_halted, o_fault;
  logic [31:0] o_fault_addr;

  int n_cmp = 0;
  int n_bad = 0;

  ex_mem_stage dut (
    .clk(clk), .i_reset(i_reset), .i_step(i_step), .i_flush(i_flush),
    .i_alu_result(i_alu_result), .i_store_data(i_store_data), .i_write_reg(i_write_reg),
    .i_mem2Reg(i_mem2Reg), .i_memRead(i_memRead), .i_memWrite(i_memWrite),
    .i_regWrite(i_regWrite), .i_sign_flag(i_sign_flag), .i_width(i_width), .i_halt(i_halt),
    .o_alu_result(o_alu_result), .o_store_data(o_store_data), .o_byte_en(o_byte_en),
    .o_write_reg(o_write_reg), .o_mem2Reg(o_mem2Reg), .o_memRead(o_memRead),
    .o_memWrite(o_memWrite), .o_regWrite(o_regWrite), .o_sign_flag(o_sign_flag),
    .o_width(o_width), .o_addr_lo(o_addr_lo), .o_halted(o_halted), .o_fault(o_fault),
    .o_fault_addr(o_fault_addr)
  );

  always #5 clk = ~clk;

  // Reference model: 0 = running, 1 = halted, 2 = faulted
  int          m_state = 0;
  logic [31:0] m_alu, m_sd, m_faddr;
  logic [3:0]  m_be;
  logic [4:0]  m_wreg;
  logic [1:0]  m_width, m_alo;
  logic        m_m2r, m_rd, m_wr, m_rw, m_sf, m_halted, m_fault, m_sd_chk;

  always @(posedge clk) begin
    int size;
    bit mis, bub;
    if (!i_reset) begin
      m_state = 0; m_alu = 0; m_sd = 0; m_faddr = 0; m_be = 0; m_wreg = 0;
      m_width = 0; m_alo = 0; m_m2r = 0; m_rd = 0; m_wr = 0; m_rw = 0; m_sf = 0;
      m_halted = 0; m_fault = 0; m_sd_chk = 1;
    end else if (m_state == 0 && !i_step) begin
      size = (i_width == 0) ? 1 : (i_width == 1) ? 2 : 4;
      mis  = (i_memRead || i_memWrite) && (i_alu_result % size != 0);
      bub  = i_flush || mis || i_halt;
      m_alu = i_alu_result;
      m_wreg = i_write_reg;
      m_alo = 2'(i_alu_result % 4);
      m_sd = (size == 1) ? i_store_data[7:0] * 32'h0101_0101 :
             (size == 2) ? i_store_data[15:0] * 32'h0001_0001 : i_store_data;
      m_sd_chk = !bub;
      if (bub) begin
        m_m2r = 0; m_rd = 0; m_wr = 0; m_rw = 0; m_sf = 0; m_width = 0; m_be = 0;
      end else begin
        m_m2r = i_mem2Reg; m_rd = i_memRead; m_wr = i_memWrite; m_rw = i_regWrite;
        m_sf = i_sign_flag; m_width = i_width;
        if (!i_memWrite) m_be = 0;
        else if (size == 1) m_be = 4'(1 << (i_alu_result % 4));
        else if (size == 2) m_be = 4'(3 << (2 * ((i_alu_result % 4) / 2)));
        else m_be = 4'hF;
      end
      if (!i_flush && mis) begin
        m_state = 2; m_fault = 1; m_faddr = i_alu_result;
      end else if (!i_flush && i_halt) begin
        m_state = 1; m_halted = 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] w,
                        input logic rd, input logic wr, input logic rw);
    i_alu_result = addr; i_store_data = data; i_width = w;
    i_memRead = rd; i_memWrite = wr; i_regWrite = rw;
    i_write_reg = 5'd7; i_mem2Reg = rd; i_sign_flag = 1'b0;
    i_flush = 1'b0; i_halt = 1'b0; i_step = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] all_out;
    i_reset = 0; i_step = 0; i_flush = 0; i_halt = 0;
    i_alu_result = $urandom; i_store_data = $urandom; i_write_reg = 5'($urandom);
    i_mem2Reg = 1; i_memRead = 1; i_memWrite = 1; i_regWrite = 1; i_sign_flag = 1; i_width = 2'b10;
    tick(); tick();
    all_out = o_alu_result | o_store_data | o_fault_addr |
              {o_byte_en, o_write_reg, o_mem2Reg, o_memRead, o_memWrite, o_regWrite,
               o_sign_flag, o_width, o_addr_lo, o_fault};
    n_cmp++;
    if (all_out !== 32'h0) begin
      n_bad++; $display("FAIL reset_outputs: got %h expected 0", all_out);
    end
    n_cmp++;
    if (o_halted !== 1'b0) begin
      n_bad++; $display("FAIL reset_halted: got %b expected 0", o_halted);
    end
  endtask

  task automatic test_byte_store();
    i_reset = 1;
    set_in(32'h0000_1002, 32'hAABB_CCDD, 2'b00, 0, 1, 0);
    tick();
    i_step = 1;
    n_cmp++;
    if (o_store_data !== 32'hDDDD_DDDD) begin
      n_bad++; $display("FAIL byte_data: got %h expected DDDDDDDD", o_store_data);
    end
    n_cmp++;
    if (o_byte_en !== 4'b0100 || o_addr_lo !== 2'b10 || o_memWrite !== 1'b1) begin
      n_bad++; $display("FAIL byte_lane: got be=%b lo=%b wr=%b expected 0100/10/1",
                        o_byte_en, o_addr_lo, o_memWrite);
    end
  endtask

  task automatic test_half_word();
    set_in(32'h12, 32'h1234_5678, 2'b01, 0, 1, 0);
    tick();
    n_cmp++;
    if (o_store_data !== 32'h5678_5678 || o_byte_en !== 4'b1100) begin
      n_bad++; $display("FAIL half_store: got %h/%b expected 56785678/1100", o_store_data, o_byte_en);
    end
    set_in(32'h10, 32'h1234_5678, 2'b10, 0, 1, 0);
    tick();
    i_step = 1;
    n_cmp++;
    if (o_store_data !== 32'h1234_5678 || o_byte_en !== 4'b1111) begin
      n_bad++; $display("FAIL word_store: got %h/%b expected 12345678/1111", o_store_data, o_byte_en);
    end
  endtask

  task automatic test_step_flush();
    for (int i = 0; i < 3; i++) begin
      i_step = 1; i_alu_result = $urandom; i_store_data = $urandom; i_memWrite = 0; i_width = 2'b00;
      tick();
      n_cmp++;
      if (o_alu_result !== 32'h10 || o_byte_en !== 4'b1111 || o_memWrite !== 1'b1) begin
        n_bad++; $display("FAIL step_hold: got %h/%b/%b expected 00000010/1111/1",
                          o_alu_result, o_byte_en, o_memWrite);
      end
    end
    set_in(32'h44, 32'h1, 2'b10, 0, 1, 1);
    i_flush = 1;
    tick();
    i_step = 1;
    n_cmp++;
    if (o_regWrite !== 1'b0 || o_memWrite !== 1'b0 || o_byte_en !== 4'b0 || o_alu_result !== 32'h44) begin
      n_bad++; $display("FAIL flush: got rw=%b wr=%b be=%b alu=%h expected 0/0/0000/00000044",
                        o_regWrite, o_memWrite, o_byte_en, o_alu_result);
    end
  endtask

  task automatic test_misaligned();
    set_in(32'h21, 32'h0, 2'b10, 1, 0, 1);
    tick();
    n_cmp++;
    if (o_memRead !== 1'b0 || o_regWrite !== 1'b0 || o_fault !== 1'b1 || o_fault_addr !== 32'h21) begin
      n_bad++; $display("FAIL misaligned: got rd=%b rw=%b f=%b fa=%h expected 0/0/1/00000021",
                        o_memRead, o_regWrite, o_fault, o_fault_addr);
    end
    for (int i = 0; i < 2; i++) begin
      set_in(32'h100 + 32'(i * 4), 32'hCAFE, 2'b10, 0, 1, 1);
      tick();
      n_cmp++;
      if (o_alu_result !== 32'h21 || o_memWrite !== 1'b0 || o_fault_addr !== 32'h21 || o_halted !== 1'b0) begin
        n_bad++; $display("FAIL fault_freeze: got alu=%h wr=%b fa=%h h=%b expected 00000021/0/00000021/0",
                          o_alu_result, o_memWrite, o_fault_addr, o_halted);
      end
    end
    i_reset = 0; tick(); i_reset = 1;
    // Halt on a misaligned access: the fault wins.
    set_in(32'h3, 32'h0, 2'b01, 0, 1, 0);
    i_halt = 1;
    tick();
    n_cmp++;
    if (o_fault !== 1'b1 || o_halted !== 1'b0) begin
      n_bad++; $display("FAIL halt_vs_fault: got f=%b h=%b expected 1/0", o_fault, o_halted);
    end
    i_reset = 0; tick(); i_reset = 1;
  endtask

  task automatic test_halt();
    set_in(32'h8, 32'h0, 2'b10, 0, 0, 1);
    i_halt = 1; i_flush = 1;
    tick();
    n_cmp++;
    if (o_halted !== 1'b0 || o_alu_result !== 32'h8) begin
      n_bad++; $display("FAIL halt_flush: got h=%b alu=%h expected 0/00000008", o_halted, o_alu_result);
    end
    set_in(32'hC, 32'h0, 2'b10, 0, 0, 1);
    i_halt = 1;
    tick();
    n_cmp++;
    if (o_halted !== 1'b1 || o_regWrite !== 1'b0) begin
      n_bad++; $display("FAIL halt_capture: got h=%b rw=%b expected 1/0", o_halted, o_regWrite);
    end
    set_in(32'h200, 32'h55, 2'b10, 0, 1, 0);
    tick();
    n_cmp++;
    if (o_alu_result !== 32'hC || o_memWrite !== 1'b0 || o_halted !== 1'b1) begin
      n_bad++; $display("FAIL halt_freeze: got alu=%h wr=%b h=%b expected 0000000C/0/1",
                        o_alu_result, o_memWrite, o_halted);
    end
    i_reset = 0; tick();
    n_cmp++;
    if (o_halted !== 1'b0 || o_alu_result !== 32'h0) begin
      n_bad++; $display("FAIL halt_reset: got h=%b alu=%h expected 0/00000000", o_halted, o_alu_result);
    end
    i_reset = 1;
    set_in(32'h300, 32'h77, 2'b10, 0, 1, 0);
    tick();
    n_cmp++;
    if (o_alu_result !== 32'h300 || o_byte_en !== 4'b1111) begin
      n_bad++; $display("FAIL post_reset_capture: got alu=%h be=%b expected 00000300/1111",
                        o_alu_result, o_byte_en);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      i_reset      = !((m_state != 0 && $urandom_range(3) == 0) || $urandom_range(40) == 0);
      i_step       = ($urandom_range(3) == 0);
      i_flush      = ($urandom_range(7) == 0);
      i_halt       = ($urandom_range(15) == 0);
      i_alu_result = $urandom;
      i_store_data = $urandom;
      i_write_reg  = 5'($urandom);
      i_mem2Reg    = 1'($urandom); i_memRead = 1'($urandom); i_memWrite = 1'($urandom);
      i_regWrite   = 1'($urandom); i_sign_flag = 1'($urandom);
      i_width      = 2'($urandom);
      // Keep misalignment rare enough that plenty of normal traffic flows.
      if ($urandom_range(3) != 0) i_alu_result[1:0] = 2'b00;
      tick();
      n_cmp++;
      if ({o_alu_result, o_write_reg, o_addr_lo} !== {m_alu, m_wreg, m_alo}) begin
        n_bad++; $display("FAIL rand_data[%0d]: got %h/%h/%h expected %h/%h/%h", i,
                          o_alu_result, o_write_reg, o_addr_lo, m_alu, m_wreg, m_alo);
      end
      n_cmp++;
      if ({o_mem2Reg, o_memRead, o_memWrite, o_regWrite, o_sign_flag, o_width, o_byte_en} !==
          {m_m2r, m_rd, m_wr, m_rw, m_sf, m_width, m_be}) begin
        n_bad++; $display("FAIL rand_ctrl[%0d]: got %b%b%b%b%b w=%b be=%b expected %b%b%b%b%b w=%b be=%b", i,
                          o_mem2Reg, o_memRead, o_memWrite, o_regWrite, o_sign_flag, o_width, o_byte_en,
                          m_m2r, m_rd, m_wr, m_rw, m_sf, m_width, m_be);
      end
      n_cmp++;
      if ({o_halted, o_fault, o_fault_addr} !== {m_halted, m_fault, m_faddr}) begin
        n_bad++; $display("FAIL rand_status[%0d]: got h=%b f=%b fa=%h expected h=%b f=%b fa=%h", i,
                          o_halted, o_fault, o_fault_addr, m_halted, m_fault, m_faddr);
      end
      if (m_sd_chk) begin
        n_cmp++;
        if (o_store_data !== m_sd) begin
          n_bad++; $display("FAIL rand_store[%0d]: got %h expected %h", i, o_store_data, m_sd);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_byte_store();
    test_half_word();
    test_step_flush();
    test_misaligned();
    test_halt();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

EX/MEM pipeline stage register sitting directly downstream of the ID/EX register and the ALU; captures the ALU result and the surviving control bits and presents them to the data-memory stage. Also aligns store data into byte lanes and generates byte enables. Detects misaligned accesses and squashes them into a sticky fault. Holds the pipeline in a halted state once a halt instruction reaches this stage.

## Interface
- No parameters.
- clk  in  1  clock, rising edge
- i_reset  in  1  reset, synchronous, active-low
- i_step  in  1  advance enable, active-low: the stage captures only when i_step = 0
- i_flush  in  1  capture a bubble instead of the incoming instruction
- i_alu_result  in  32  ALU result; the memory address for loads and stores
- i_store_data  in  32  forwarded rt value (store source)
- i_write_reg  in  5  destination register index
- i_mem2Reg, i_memRead, i_memWrite, i_regWrite, i_sign_flag  in  1 each  control from ID/EX
- i_width  in  2  access width: 00 byte, 01 half, 10 word, 11 treated as word
- i_halt  in  1  instruction in EX is HALT
- o_alu_result  out  32  registered ALU result / address
- o_store_data  out  32  lane-aligned store data
- o_byte_en  out  4  byte write enables, bit n = byte lane n
- o_write_reg  out  5  registered destination index
- o_mem2Reg, o_memRead, o_memWrite, o_regWrite, o_sign_flag  out  1 each  registered control
- o_width  out  2  registered width
- o_addr_lo  out  2  registered i_alu_result[1:0], for load extraction downstream
- o_halted  out  1  stage is in HALTED
- o_fault  out  1  sticky misaligned-access fault
- o_fault_addr  out  32  address of the first faulting access

## Operation
- Reset (i_reset = 0 at a clock edge) clears every output to 0 and sets state to RUN. This takes priority over all other inputs.
- States: RUN, HALTED, FAULT.
- RUN, i_step = 0: the stage captures. Otherwise all outputs hold.
- Capture with i_flush = 1: the stage captures a bubble.
  - Data fields still take the incoming values.
  - All control outputs are 0: mem2Reg, memRead, memWrite, regWrite, sign_flag, width = 00, byte_en = 0000.
  - i_halt is ignored.
  - i_flush has priority over both i_halt and misalignment detection.
- Misalignment is evaluated only when i_memRead or i_memWrite is 1:
  - half access with addr[0] = 1;
  - word access with addr[1:0] != 00.
- Normal capture (not flushed, not misaligned):
  - Data and control pass straight through.
  - Store alignment by width, using a = addr[1:0]:
    - byte: store_data = {4{i_store_data[7:0]}}, byte_en = 0001 << a.
    - half: store_data = {2{i_store_data[15:0]}}, byte_en = 0011 << (2*a[1]).
    - word: store_data = i_store_data unchanged, byte_en = 1111.
  - o_byte_en = 0000 whenever the captured memWrite is 0.
- Misaligned capture:
  - The stage captures a bubble: controls cleared as for a flush.
  - o_fault <= 1 and o_fault_addr <= i_alu_result.
  - State -> FAULT.
- Halt capture (i_halt = 1, not flushed):
  - The halt instruction is captured as a bubble.
  - State -> HALTED; o_halted <= 1.
- HALTED and FAULT:
  - All registered outputs freeze and i_step is ignored.
  - The only exit is reset.
  - o_fault and o_fault_addr never change outside reset.
- Simultaneous halt and misalignment on the same instruction: misalignment wins, state -> FAULT, o_halted stays 0.

## Timing
- Latency: 1 clock. Inputs sampled at edge k appear on outputs after edge k.
- All outputs are registered. There is no combinational path from input to output.
- o_halted and o_fault rise in the same cycle in which the triggering capture appears on the outputs.
- A step pulse (i_step = 0) lasting exactly one cycle advances the stage exactly once.
- Reset asserted mid-halt or mid-fault returns the stage to RUN with zeroed outputs on the next edge. The stage resumes capturing on the first edge after reset deasserts with i_step = 0.

## Test plan
- Reset behaviour: hold i_reset = 0 for 2 cycles with arbitrary inputs -> every output is 0 and o_halted = 0.
- Byte store, lane 2: addr = 0x0000_1002, store_data = 0xAABB_CCDD, width = 00, memWrite = 1 -> o_store_data = 0xDDDD_DDDD, o_byte_en = 0100, o_addr_lo = 10.
- Half and word stores:
  - half store, addr = 0x12, data = 0x1234_5678 -> o_store_data = 0x5678_5678, o_byte_en = 1100;
  - word store, addr = 0x10 -> o_byte_en = 1111 and data unchanged.
- Misaligned word load: memRead = 1, regWrite = 1, addr = 0x0000_0021, width = 10 -> o_memRead = 0, o_regWrite = 0, o_fault = 1, o_fault_addr = 0x21. Later captures with i_step = 0 leave every output frozen.
- Step and flush:
  - i_step = 1 for 3 cycles with changing inputs -> outputs hold;
  - flush capture with regWrite = 1 and memWrite = 1 -> both outputs 0, o_alu_result still updates.
- Halt sequencing:
  - i_halt = 1 captured -> o_halted = 1 next cycle, and the stage ignores the following valid store;
  - i_halt together with i_flush -> o_halted stays 0;
  - reset while halted -> RUN, and a subsequent capture works.
